beacon_peak_detector: RTL and testbench
=======================================

BEACON_PEAK_DETECTOR -- requirements
Module: beacon_peak_detector

Interface
REQ-001 The block SHALL have the parameter PERIOD_BITS, default 8, meaning the log2 of the code period in samples (epoch = 2^PERIOD_BITS cycles).
REQ-002 The block SHALL have the parameter LOCK_COUNT, default 3, meaning the number of consecutive consistent detections needed to declare lock.
REQ-003 The block SHALL have the parameter MISS_COUNT, default 2, meaning the number of consecutive failed epochs that drops lock.
REQ-004 The block SHALL have the parameter PHASE_TOL, default 1, meaning the maximum circular phase distance between successive peaks that still counts as consistent.
REQ-005 Port clk, input, 1: the single clock; all logic SHALL be on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Port value, input, 8: the correlator match count, one new sample per clk.
REQ-008 Port threshold, input, 8: the minimum epoch maximum that counts as a detection, sampled at epoch end.
REQ-009 Port peak_valid, output, 1: a one-cycle pulse meaning an epoch ended with a detection.
REQ-010 Port peak_value, output, 8: the epoch maximum, held until the next peak_valid.
REQ-011 Port peak_phase, output, PERIOD_BITS: the phase index of that maximum, held until the next peak_valid.
REQ-012 Port locked, output, 1: high while the state machine is in LOCKED.

Function
REQ-013 A phase counter SHALL count from 0 to 2^PERIOD_BITS-1 and wrap, advancing by 1 every cycle.
REQ-014 Within an epoch, the block SHALL track the maximum value and its phase, replacing them only on a strictly greater value, so ties keep the earliest phase.
REQ-015 The first sample of each epoch (phase 0) SHALL unconditionally initialise the running max and phase.
REQ-016 The sample at the last phase SHALL take part in the comparison, and the final max/phase SHALL be evaluated combinationally with it.
REQ-017 On the cycle after the last-phase sample, the block SHALL assert peak_valid if the final max >= threshold (equality counts), with peak_value and peak_phase updated on the same edge.
REQ-018 A detection that fails threshold SHALL NOT assert peak_valid, SHALL leave peak_value/peak_phase unchanged, and SHALL count as a miss.
REQ-019 Phase distance SHALL be circular modulo 2^PERIOD_BITS (e.g. 255 vs 0 = 1 for PERIOD_BITS=8).
REQ-020 The state machine SHALL have the states SEARCH, CONFIRM and LOCKED, and SHALL evaluate only at epoch end.
REQ-021 In SEARCH, a detection SHALL go to CONFIRM with hit count 1 and store the reference phase; a miss SHALL stay in SEARCH.
REQ-022 In CONFIRM, a consistent detection (distance <= PHASE_TOL) SHALL increment hit count and update the reference phase; reaching LOCK_COUNT SHALL go to LOCKED.
REQ-023 In CONFIRM, an inconsistent detection SHALL restart CONFIRM with hit count 1 and the new reference phase; a miss SHALL return to SEARCH.
REQ-024 In LOCKED, a consistent detection SHALL clear the miss count and update the reference phase.
REQ-025 In LOCKED, a miss or inconsistent detection SHALL increment the miss count, and reaching MISS_COUNT SHALL return to SEARCH with all counts cleared.
REQ-026 locked SHALL update on the same edge as peak_valid, and SHALL be registered with no combinational path from value.
REQ-027 Latency from the last-phase sample to peak_valid/locked SHALL be 1 cycle.

Reset
REQ-028 While rst is high, the block SHALL hold: phase=0, state=SEARCH, hit and miss counts=0, running max=0, peak_valid=0, peak_value=0, peak_phase=0, locked=0.
REQ-029 The first cycle after rst deasserts SHALL be phase 0, and its sample SHALL be accepted.
REQ-030 Reset asserted mid-epoch SHALL discard the partial epoch with no peak_valid.

Structure
REQ-031 The state enumeration, its encoding width and the default PERIOD_BITS SHALL reside in the shared package beacon_pkg.
REQ-032 The epoch max/argmax tracking (REQ-014..016) SHALL be the sub-module epoch_max_tracker; the FSM and outputs SHALL be in the top.

Verification
REQ-033 Bench: value=200 at phase 37, 10 elsewhere, threshold=100, for one epoch -> peak_valid pulse at cycle 257 after reset release, peak_value=200, peak_phase=37, locked=0.
REQ-034 Bench: peak 150 at phases 37, 38, 37 over three epochs -> locked rises with the third peak_valid.
REQ-035 Bench: while locked, two epochs all-zero -> locked falls at the end of the second, no peak_valid in either.
REQ-036 Bench: value=180 at phases 10 and 90 in one epoch -> peak_phase=10; value equal to threshold (=180) -> peak_valid asserted.
REQ-037 Bench: peaks at phases 255, 0, 1 across epochs with PHASE_TOL=1 -> counted consistent, locked asserted.
REQ-038 Bench: rst pulsed at phase 128 while LOCKED -> locked=0 next cycle, no peak_valid until 256 cycles after release.

Source files
------------

// File: rtl/beacon_pkg.sv
// Shared types and defaults for the beacon peak detector slice.
package beacon_pkg;

  localparam int unsigned DEFAULT_PERIOD_BITS = 8;
  localparam int unsigned VALUE_W             = 8;
  localparam int unsigned STATE_W             = 2;
  localparam int unsigned CNT_W               = 8;

  typedef enum logic [STATE_W-1:0] {
    SEARCH  = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_e;

endpackage

// File: rtl/beacon_peak_detector_if.sv
// Sample input / peak report bundle of the beacon peak detector.
interface beacon_peak_detector_if
  import beacon_pkg::*;
#(
  parameter int unsigned PERIOD_BITS = DEFAULT_PERIOD_BITS
);

  logic [VALUE_W-1:0]     value;
  logic [VALUE_W-1:0]     threshold;
  logic                   peak_valid;
  logic [VALUE_W-1:0]     peak_value;
  logic [PERIOD_BITS-1:0] peak_phase;
  logic                   locked;

  modport master (
    output value, threshold,
    input  peak_valid, peak_value, peak_phase, locked
  );

  modport slave (
    input  value, threshold,
    output peak_valid, peak_value, peak_phase, locked
  );

endinterface

// File: rtl/epoch_max_tracker.sv
// Running max/argmax over one epoch; the final result includes the current sample.
module epoch_max_tracker
  import beacon_pkg::*;
#(
  parameter int unsigned PERIOD_BITS = DEFAULT_PERIOD_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PERIOD_BITS-1:0] phase,
  input  logic [VALUE_W-1:0]     value,
  output logic [VALUE_W-1:0]     final_max_c,
  output logic [PERIOD_BITS-1:0] final_phase_c
);

  logic [VALUE_W-1:0]     run_max_q;
  logic [PERIOD_BITS-1:0] run_phase_q;

  // Phase 0 restarts the epoch; later samples win only when strictly greater.
  always_comb begin
    final_max_c   = run_max_q;
    final_phase_c = run_phase_q;
    if (phase == '0) begin
      final_max_c   = value;
      final_phase_c = phase;
    end else if (value > run_max_q) begin
      final_max_c   = value;
      final_phase_c = phase;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_max_q   <= '0;
      run_phase_q <= '0;
    end else begin
      run_max_q   <= final_max_c;
      run_phase_q <= final_phase_c;
    end
  end

endmodule

// File: rtl/beacon_peak_detector.sv
// Per-epoch peak detection with a SEARCH/CONFIRM/LOCKED phase-lock state machine.
module beacon_peak_detector
  import beacon_pkg::*;
#(
  parameter int unsigned PERIOD_BITS = DEFAULT_PERIOD_BITS,
  parameter int unsigned LOCK_COUNT  = 3,
  parameter int unsigned MISS_COUNT  = 2,
  parameter int unsigned PHASE_TOL   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  beacon_peak_detector_if.slave   bus
);

  logic [PERIOD_BITS-1:0] phase_q;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       hit_q, hit_d;
  logic [CNT_W-1:0]       miss_q, miss_d;
  logic [PERIOD_BITS-1:0] ref_q, ref_d;

  logic                   peak_valid_q, peak_valid_d;
  logic [VALUE_W-1:0]     peak_value_q, peak_value_d;
  logic [PERIOD_BITS-1:0] peak_phase_q, peak_phase_d;
  logic                   locked_q, locked_d;

  logic [VALUE_W-1:0]     final_max_c;
  logic [PERIOD_BITS-1:0] final_phase_c;
  logic                   epoch_end_c;
  logic                   detect_c;
  logic [PERIOD_BITS-1:0] dist_fwd_c, dist_bwd_c, dist_c;
  logic                   consistent_c;

  epoch_max_tracker #(
    .PERIOD_BITS (PERIOD_BITS)
  ) u_tracker (
    .clk           (clk),
    .rst           (rst),
    .phase         (phase_q),
    .value         (bus.value),
    .final_max_c   (final_max_c),
    .final_phase_c (final_phase_c)
  );

  always_ff @(posedge clk) begin
    if (rst) phase_q <= '0;
    else     phase_q <= phase_q + PERIOD_BITS'(1);
  end

  // Circular phase distance: modular subtraction both ways, keep the shorter.
  always_comb begin
    epoch_end_c  = (phase_q == '1);
    detect_c     = epoch_end_c && (final_max_c >= bus.threshold);
    dist_fwd_c   = final_phase_c - ref_q;
    dist_bwd_c   = ref_q - final_phase_c;
    dist_c       = (dist_fwd_c < dist_bwd_c) ? dist_fwd_c : dist_bwd_c;
    consistent_c = (dist_c <= PERIOD_BITS'(PHASE_TOL));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEARCH;
      hit_q   <= '0;
      miss_q  <= '0;
      ref_q   <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      ref_q   <= ref_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    ref_d   = ref_q;
    if (epoch_end_c) begin
      case (state_q)
        SEARCH: begin
          if (detect_c) begin
            state_d = CONFIRM;
            hit_d   = CNT_W'(1);
            miss_d  = '0;
            ref_d   = final_phase_c;
          end
        end
        CONFIRM: begin
          if (!detect_c) begin
            state_d = SEARCH;
            hit_d   = '0;
          end else if (consistent_c) begin
            hit_d = hit_q + CNT_W'(1);
            ref_d = final_phase_c;
            if (hit_d >= CNT_W'(LOCK_COUNT)) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            hit_d = CNT_W'(1);
            ref_d = final_phase_c;
          end
        end
        LOCKED: begin
          if (detect_c && consistent_c) begin
            miss_d = '0;
            ref_d  = final_phase_c;
          end else begin
            miss_d = miss_q + CNT_W'(1);
            if (miss_d >= CNT_W'(MISS_COUNT)) begin
              state_d = SEARCH;
              hit_d   = '0;
              miss_d  = '0;
            end
          end
        end
        default: begin
          state_d = SEARCH;
          hit_d   = '0;
          miss_d  = '0;
        end
      endcase
    end
  end

  // Report values move only on a passing epoch; locked follows the next state.
  always_comb begin
    peak_valid_d = detect_c;
    peak_value_d = peak_value_q;
    peak_phase_d = peak_phase_q;
    locked_d     = (state_d == LOCKED);
    if (detect_c) begin
      peak_value_d = final_max_c;
      peak_phase_d = final_phase_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_valid_q <= 1'b0;
      peak_value_q <= '0;
      peak_phase_q <= '0;
      locked_q     <= 1'b0;
    end else begin
      peak_valid_q <= peak_valid_d;
      peak_value_q <= peak_value_d;
      peak_phase_q <= peak_phase_d;
      locked_q     <= locked_d;
    end
  end

  assign bus.peak_valid = peak_valid_q;
  assign bus.peak_value = peak_value_q;
  assign bus.peak_phase = peak_phase_q;
  assign bus.locked     = locked_q;

endmodule

// File: tb/tb_beacon_peak_detector.sv
// Directed bench for beacon_peak_detector with hand-computed epoch results.
module tb_beacon_peak_detector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  beacon_peak_detector_if #(.PERIOD_BITS(8)) bus ();

  beacon_peak_detector #(
    .PERIOD_BITS (8),
    .LOCK_COUNT  (3),
    .MISS_COUNT  (2),
    .PHASE_TOL   (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic       pv;
  logic [7:0] pval;
  logic [7:0] pph;
  logic       lk;
  int         spur;

  // Caller is at posedge+1 with rst low; drives 256 samples, then reads the result cycle.
  task automatic run_epoch(input int p1, input int v1, input int p2, input int v2,
                           input int base, input int thr);
    spur = 0;
    bus.threshold = 8'(thr);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (i > 0 && bus.peak_valid !== 1'b0) spur++;
      if (i == p1)      bus.value = 8'(v1);
      else if (i == p2) bus.value = 8'(v2);
      else              bus.value = 8'(base);
    end
    @(posedge clk);
    #1;
    pv   = bus.peak_valid;
    pval = bus.peak_value;
    pph  = bus.peak_phase;
    lk   = bus.locked;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.value = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.value = 8'd77;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (bus.peak_valid !== 1'b0) begin failures++; $display("FAIL reset_pv got %0d want 0", bus.peak_valid); end
    if (bus.peak_value !== 8'd0) begin failures++; $display("FAIL reset_pval got %0d want 0", bus.peak_value); end
    if (bus.peak_phase !== 8'd0) begin failures++; $display("FAIL reset_pph got %0d want 0", bus.peak_phase); end
    if (bus.locked !== 1'b0)     begin failures++; $display("FAIL reset_lock got %0d want 0", bus.locked); end
    rst = 1'b0;
  endtask

  task automatic test_single_peak();
    run_epoch(37, 200, -1, 0, 10, 100);
    checks += 5;
    if (spur != 0)      begin failures++; $display("FAIL single_spur got %0d want 0", spur); end
    if (pv !== 1'b1)    begin failures++; $display("FAIL single_pv@257 got %0d want 1", pv); end
    if (pval !== 8'd200) begin failures++; $display("FAIL single_pval got %0d want 200", pval); end
    if (pph !== 8'd37)  begin failures++; $display("FAIL single_pph got %0d want 37", pph); end
    if (lk !== 1'b0)    begin failures++; $display("FAIL single_lock got %0d want 0", lk); end
  endtask

  task automatic test_lock();
    do_reset();
    run_epoch(37, 150, -1, 0, 10, 100);
    checks += 2;
    if (pv !== 1'b1) begin failures++; $display("FAIL lock_e1_pv got %0d want 1", pv); end
    if (lk !== 1'b0) begin failures++; $display("FAIL lock_e1_lock got %0d want 0", lk); end
    run_epoch(38, 150, -1, 0, 10, 100);
    checks += 2;
    if (pph !== 8'd38) begin failures++; $display("FAIL lock_e2_pph got %0d want 38", pph); end
    if (lk !== 1'b0)   begin failures++; $display("FAIL lock_e2_lock got %0d want 0", lk); end
    run_epoch(37, 150, -1, 0, 10, 100);
    checks += 3;
    if (pv !== 1'b1)   begin failures++; $display("FAIL lock_e3_pv got %0d want 1", pv); end
    if (pph !== 8'd37) begin failures++; $display("FAIL lock_e3_pph got %0d want 37", pph); end
    if (lk !== 1'b1)   begin failures++; $display("FAIL lock_e3_lock got %0d want 1", lk); end
  endtask

  task automatic test_loss();
    run_epoch(-1, 0, -1, 0, 0, 100);
    checks += 3;
    if (pv !== 1'b0 || spur != 0) begin failures++; $display("FAIL loss_e1_pv got %0d/%0d want 0/0", pv, spur); end
    if (lk !== 1'b1) begin failures++; $display("FAIL loss_e1_lock got %0d want 1", lk); end
    if (pval !== 8'd150) begin failures++; $display("FAIL loss_e1_hold got %0d want 150", pval); end
    run_epoch(-1, 0, -1, 0, 0, 100);
    checks += 3;
    if (pv !== 1'b0 || spur != 0) begin failures++; $display("FAIL loss_e2_pv got %0d/%0d want 0/0", pv, spur); end
    if (lk !== 1'b0) begin failures++; $display("FAIL loss_e2_lock got %0d want 0", lk); end
    if (pph !== 8'd37) begin failures++; $display("FAIL loss_e2_hold got %0d want 37", pph); end
  endtask

  task automatic test_tie_threshold();
    do_reset();
    run_epoch(10, 180, 90, 180, 0, 180);
    checks += 3;
    if (pv !== 1'b1)     begin failures++; $display("FAIL tie_pv got %0d want 1", pv); end
    if (pph !== 8'd10)   begin failures++; $display("FAIL tie_pph got %0d want 10", pph); end
    if (pval !== 8'd180) begin failures++; $display("FAIL tie_pval got %0d want 180", pval); end
    run_epoch(200, 180, -1, 0, 3, 181);
    checks += 2;
    if (pv !== 1'b0)   begin failures++; $display("FAIL below_thr_pv got %0d want 0", pv); end
    if (pph !== 8'd10) begin failures++; $display("FAIL below_thr_hold got %0d want 10", pph); end
  endtask

  task automatic test_wrap();
    do_reset();
    run_epoch(255, 120, -1, 0, 5, 100);
    checks += 2;
    if (pv !== 1'b1 || pph !== 8'd255) begin failures++; $display("FAIL wrap_e1 got pv=%0d ph=%0d want 1/255", pv, pph); end
    if (lk !== 1'b0) begin failures++; $display("FAIL wrap_e1_lock got %0d want 0", lk); end
    run_epoch(0, 120, -1, 0, 5, 100);
    checks += 1;
    if (pv !== 1'b1 || pph !== 8'd0) begin failures++; $display("FAIL wrap_e2 got pv=%0d ph=%0d want 1/0", pv, pph); end
    run_epoch(1, 120, -1, 0, 5, 100);
    checks += 2;
    if (pph !== 8'd1) begin failures++; $display("FAIL wrap_e3_pph got %0d want 1", pph); end
    if (lk !== 1'b1)  begin failures++; $display("FAIL wrap_e3_lock got %0d want 1", lk); end
  endtask

  task automatic test_mid_reset();
    bus.threshold = 8'd100;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      bus.value = (i == 5) ? 8'd200 : 8'd0;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks += 2;
    if (bus.locked !== 1'b0)     begin failures++; $display("FAIL midrst_lock got %0d want 0", bus.locked); end
    if (bus.peak_valid !== 1'b0) begin failures++; $display("FAIL midrst_pv got %0d want 0", bus.peak_valid); end
    rst = 1'b0;
    run_epoch(-1, 0, -1, 0, 0, 0);
    checks += 3;
    if (spur != 0)     begin failures++; $display("FAIL midrst_early_pv got %0d want 0", spur); end
    if (pv !== 1'b1)   begin failures++; $display("FAIL midrst_pv@257 got %0d want 1", pv); end
    if (pval !== 8'd0 || pph !== 8'd0) begin failures++; $display("FAIL midrst_peak got %0d/%0d want 0/0", pval, pph); end
  endtask

  initial begin
    bus.value = 8'd0;
    bus.threshold = 8'd0;
    test_reset();
    test_single_peak();
    test_lock();
    test_loss();
    test_tie_threshold();
    test_wrap();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
